fetch_queue: RTL

Instruction fetch stage placed directly upstream of the single-cycle datapath. It issues word addresses to the synchronous instruction memory, buffers the returned 20-bit instructions together with their PCs in a small FIFO, and presents them to the datapath through a valid/ready handshake. Taken branches and jumps computed downstream arrive as a redirect, which flushes the queue, squashes any in-flight fetch and restarts fetching at the target.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 73 +++++++
 rtl/fetch_queue.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Optional build macro used by this slice: FETCH_QUEUE_PERF_EN (performance counters).
package fetch_pkg;

  localparam int FETCH_DATA_WIDTH = 20;
  localparam int FETCH_ADDR_WIDTH = 8;
  localparam int FETCH_DEPTH      = 4;
  localparam int FETCH_RESET_PC   = 0;
  localparam int PERF_WIDTH       = 16;

  // One buffered fetch: the instruction word and the PC it was fetched from.
  typedef struct packed {
    logic [FETCH_DATA_WIDTH-1:0] instr;
    logic [FETCH_ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;

  // Saturating increment for the performance counters.
  function automatic logic [PERF_WIDTH-1:0] sat_inc(input logic [PERF_WIDTH-1:0] v);
    return (v == '1) ? v : v + PERF_WIDTH'(1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with single-cycle flush and an occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int WIDTH = 28,
  parameter int DEPTH = FETCH_DEPTH,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer and occupancy next-state; flush overrides push and pop.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise paths that skip an assignment infer latches.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; an entry is only read once count says it was written.
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_data_o = mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign empty_o     = (count_q == '0);

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: PC generation, request credit, squash on redirect,
// and a small FIFO presenting {instr, pc} to the datapath via valid/ready.
// Build macro: FETCH_QUEUE_PERF_EN adds perf_flush_count / perf_empty_cycles.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                       DATA_WIDTH    = FETCH_DATA_WIDTH,
  parameter int                       ADDRESS_WIDTH = FETCH_ADDR_WIDTH,
  parameter int                       DEPTH         = FETCH_DEPTH,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = ADDRESS_WIDTH'(FETCH_RESET_PC)
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [ADDRESS_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0]    imem_data,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [ADDRESS_WIDTH-1:0] out_pc
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [PERF_WIDTH-1:0]    perf_flush_count,
  output logic [PERF_WIDTH-1:0]    perf_empty_cycles
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    instr;
    logic [ADDRESS_WIDTH-1:0] pc;
  } entry_t;

  logic [ADDRESS_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic                     resp_pending_q, resp_pending_d;
  logic [ADDRESS_WIDTH-1:0] resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0]         fifo_count;
  logic                     fifo_empty;
  logic                     push;
  logic                     pop;
  entry_t                   push_entry;
  entry_t                   head_entry;

  // A request is issued only if the buffered plus in-flight words still leave a free slot,
  // so a response can always be written without checking for space.
  assign imem_req  = !rst && !redirect_valid
                     && ((fifo_count + CNT_W'(resp_pending_q)) < CNT_W'(DEPTH));
  assign imem_addr = fetch_pc_q;

  // A response landing in a redirect cycle belongs to the squashed path and is dropped.
  assign push       = resp_pending_q && !redirect_valid;
  assign pop        = out_valid && out_ready;
  assign push_entry = '{instr: imem_data, pc: resp_pc_q};

  // Fetch PC and in-flight response tracking; redirect beats sequential advance.
  always_comb begin
    fetch_pc_d     = fetch_pc_q;
    resp_pending_d = imem_req;
    resp_pc_d      = imem_addr;
    if (redirect_valid) begin
      fetch_pc_d     = redirect_pc;
      resp_pending_d = 1'b0;
    end else if (imem_req) begin
      fetch_pc_d = fetch_pc_q + ADDRESS_WIDTH'(1);
    end
  end

  // Fetch control registers; reset beats redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q     <= RESET_PC;
      resp_pending_q <= 1'b0;
      resp_pc_q      <= RESET_PC;
    end else begin
      fetch_pc_q     <= fetch_pc_d;
      resp_pending_q <= resp_pending_d;
      resp_pc_q      <= resp_pc_d;
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_data_o (head_entry),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  // Outputs come from registered FIFO state only and are zeroed when nothing is buffered.
  assign out_valid = !fifo_empty;
  assign out_instr = out_valid ? head_entry.instr : '0;
  assign out_pc    = out_valid ? head_entry.pc    : '0;

`ifdef FETCH_QUEUE_PERF_EN
  logic [PERF_WIDTH-1:0] flush_cnt_q;
  logic [PERF_WIDTH-1:0] empty_cnt_q;

  // Saturating counts of redirect cycles and cycles with nothing to offer.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt_q <= '0;
      empty_cnt_q <= '0;
    end else begin
      if (redirect_valid) flush_cnt_q <= sat_inc(flush_cnt_q);
      if (!out_valid)     empty_cnt_q <= sat_inc(empty_cnt_q);
    end
  end

  assign perf_flush_count  = flush_cnt_q;
  assign perf_empty_cycles = empty_cnt_q;
`endif

endmodule
